inst_fifo: RTL and testbench
============================

INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 16, entry count; power of two, >= 4.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: flush  input  1  discard all entries (exception/branch redirect).
REQ-005 SHALL have ports: write_en1, write_en2  input  1 each  fetch pushes slot 1 / slot 2.
REQ-006 SHALL have ports: write_inst1, write_inst2, write_addr1, write_addr2  input  32 each  instruction word and PC per slot.
REQ-007 SHALL have ports: read_en1, read_en2  input  1 each  decode pops master / slave.
REQ-008 SHALL have ports: read_inst1, read_inst2, read_addr1, read_addr2  output  32 each  head and head+1 entries.
REQ-009 SHALL have ports: fifo_empty, fifo_almost_empty, fifo_full  output  1 each  occupancy flags.

Function
REQ-010 SHALL keep rptr, wptr (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits).
REQ-011 SHALL drive read_inst1/read_addr1 combinationally from mem[rptr] when count>=1, else 0.
REQ-012 SHALL drive read_inst2/read_addr2 from mem[rptr+1 mod DEPTH] when count>=2, else 0.
REQ-013 SHALL assert fifo_empty iff count==0, fifo_almost_empty iff count==1, fifo_full iff count>=DEPTH-1.
REQ-014 SHALL accept a write only when write_en1=1 and fifo_full=0; write_en2 alone is ignored.
REQ-015 SHALL store slot 1 at wptr and, if write_en2, slot 2 at wptr+1; wptr advances by 1 or 2.
REQ-016 SHALL honour read_en1 only if count>=1, read_en2 only if read_en1 honoured and count>=2; rptr advances by 0/1/2.
REQ-017 SHALL update count = count + accepted writes - honoured reads in one cycle; simultaneous read and write at full/empty boundaries are legal.
REQ-018 SHALL give flush priority: next cycle rptr=wptr=count=0; same-cycle reads and writes discarded.
REQ-019 SHALL have zero-cycle read latency; a written entry is visible on read ports the cycle after the write.
REQ-020 SHALL never overwrite unread entries; writes under fifo_full are dropped, with no other side effect.

Reset
REQ-021 SHALL, on rst high, immediately clear rptr, wptr, count: fifo_empty=1, fifo_almost_empty=0, fifo_full=0, read outputs 0.
REQ-022 SHALL leave storage array unreset; contents unobservable while count==0.
REQ-023 SHALL discard in-flight writes when rst asserts mid-cycle; normal operation resumes on the first edge after rst deasserts.

Configuration
REQ-024 SHALL, with INST_FIFO_STARVE_CNT_EN defined, add output starve_cnt (32-bit) counting cycles with count<2 and flush=0, saturating at 0xFFFFFFFF, cleared by rst only.
REQ-025 SHALL, without INST_FIFO_STARVE_CNT_EN, omit the port and counter entirely; all other behaviour identical.

Structure
REQ-026 SHALL place typedef inst_fifo_entry_t {inst[31:0], addr[31:0]} and INST_FIFO_DEPTH default constant in the shared CPU package.
REQ-027 SHALL implement storage as sub-module fifo_dual_mem (2 write ports, 2 async read ports, DEPTH entries); pointer/count logic stays in inst_fifo.

Verification
REQ-028 SHALL cover: reset, push pair (0x24010001@0xBFC00000, 0x24020002@0xBFC00004) -> next cycle count=2, read_inst1=0x24010001, read_inst2=0x24020002, empty=0, almost_empty=0.
REQ-029 SHALL cover: count=1, read_en1=read_en2=1 -> only one pop, count=0, fifo_empty=1.
REQ-030 SHALL cover: fill DEPTH=16 to count=15 -> fifo_full=1; push pair -> dropped, count stays 15, head unchanged.
REQ-031 SHALL cover: pointer wrap, 40 cycles of 2-push/2-pop -> in-order addresses, no loss or duplication, count constant.
REQ-032 SHALL cover: count=5, flush with simultaneous push and pop -> next cycle count=0, fifo_empty=1, outputs 0.
REQ-033 SHALL cover: with INST_FIFO_STARVE_CNT_EN, 10 cycles at count=1 -> starve_cnt=10; assert rst mid-run -> starve_cnt=0 immediately.

Source files
------------

// File: rtl/inst_fifo_pkg.sv
// Shared CPU package: instruction FIFO entry layout and default depth.
package inst_fifo_pkg;

  localparam int unsigned INST_FIFO_DEPTH = 16;

  // One fetched instruction together with its PC
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } inst_fifo_entry_t;

endpackage

// File: rtl/fifo_dual_mem.sv
// Storage array for inst_fifo: two write ports, two asynchronous read ports.
// Contents are not reset; the FIFO only exposes entries it has written.
module fifo_dual_mem
  import inst_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = INST_FIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we1_i,
  input  logic [AW-1:0]    waddr1_i,
  input  inst_fifo_entry_t wdata1_i,
  input  logic             we2_i,
  input  logic [AW-1:0]    waddr2_i,
  input  inst_fifo_entry_t wdata2_i,
  input  logic [AW-1:0]    raddr1_i,
  output inst_fifo_entry_t rdata1_o,
  input  logic [AW-1:0]    raddr2_i,
  output inst_fifo_entry_t rdata2_o
);

  inst_fifo_entry_t mem_q [DEPTH];

  // Write ports; the FIFO never drives both ports to the same address
  always_ff @(posedge clk) begin
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    if (we2_i) mem_q[waddr2_i] <= wdata2_i;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction FIFO between fetch and decode.
// Up to two pushes and two pops per cycle, zero-latency head/head+1 reads,
// flush for redirects. Optional starvation counter under
// INST_FIFO_STARVE_CNT_EN (adds port starve_cnt).
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = INST_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_addr1,
  input  logic [31:0] write_addr2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_addr1,
  output logic [31:0] read_addr2,
  output logic        fifo_empty,
  output logic        fifo_almost_empty,
  output logic        fifo_full
`ifdef INST_FIFO_STARVE_CNT_EN
  ,
  output logic [31:0] starve_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic             full_c;
  logic             wr1_c, wr2_c, rd1_c, rd2_c;
  logic [CW-1:0]    n_wr_c, n_rd_c;
  inst_fifo_entry_t wdata1_c, wdata2_c, rdata1_c, rdata2_c;

  // Accept/honour decisions and next pointer/count state
  always_comb begin
    full_c  = (count_q >= CW'(DEPTH - 1));
    wr1_c   = write_en1 && !full_c;
    wr2_c   = wr1_c && write_en2;
    rd1_c   = read_en1 && (count_q >= CW'(1));
    rd2_c   = rd1_c && read_en2 && (count_q >= CW'(2));
    n_wr_c  = CW'(wr1_c) + CW'(wr2_c);
    n_rd_c  = CW'(rd1_c) + CW'(rd2_c);
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      rptr_d  = rptr_q + AW'(n_rd_c);
      wptr_d  = wptr_q + AW'(n_wr_c);
      count_d = count_q + n_wr_c - n_rd_c;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  assign wdata1_c = '{inst: write_inst1, addr: write_addr1};
  assign wdata2_c = '{inst: write_inst2, addr: write_addr2};

  fifo_dual_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .we1_i    (wr1_c && !flush && !rst),
    .waddr1_i (wptr_q),
    .wdata1_i (wdata1_c),
    .we2_i    (wr2_c && !flush && !rst),
    .waddr2_i (wptr_q + AW'(1)),
    .wdata2_i (wdata2_c),
    .raddr1_i (rptr_q),
    .rdata1_o (rdata1_c),
    .raddr2_i (rptr_q + AW'(1)),
    .rdata2_o (rdata2_c)
  );

  // Read ports show zeros where the slot holds no valid entry
  always_comb begin
    read_inst1 = '0;
    read_addr1 = '0;
    read_inst2 = '0;
    read_addr2 = '0;
    if (count_q >= CW'(1)) begin
      read_inst1 = rdata1_c.inst;
      read_addr1 = rdata1_c.addr;
    end
    if (count_q >= CW'(2)) begin
      read_inst2 = rdata2_c.inst;
      read_addr2 = rdata2_c.addr;
    end
  end

  assign fifo_empty        = (count_q == '0);
  assign fifo_almost_empty = (count_q == CW'(1));
  assign fifo_full         = full_c;

`ifdef INST_FIFO_STARVE_CNT_EN
  logic [31:0] starve_q;

  // Saturating count of cycles where decode cannot dual-issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if ((count_q < CW'(2)) && !flush && (starve_q != '1)) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Directed testbench for inst_fifo (DEPTH=16).
module tb_inst_fifo;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_inst1, write_inst2, write_addr1, write_addr2;
  logic [31:0] read_inst1, read_inst2, read_addr1, read_addr2;
  logic        fifo_empty, fifo_almost_empty, fifo_full;
`ifdef INST_FIFO_STARVE_CNT_EN
  logic [31:0] starve_cnt;
`endif

  int tests = 0;
  int fails = 0;

  inst_fifo #(.DEPTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .write_en1         (write_en1),
    .write_en2         (write_en2),
    .write_inst1       (write_inst1),
    .write_inst2       (write_inst2),
    .write_addr1       (write_addr1),
    .write_addr2       (write_addr2),
    .read_en1          (read_en1),
    .read_en2          (read_en2),
    .read_inst1        (read_inst1),
    .read_inst2        (read_inst2),
    .read_addr1        (read_addr1),
    .read_addr2        (read_addr2),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_full         (fifo_full)
`ifdef INST_FIFO_STARVE_CNT_EN
    ,
    .starve_cnt        (starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; write_en1 = 1'b0; write_en2 = 1'b0;
    read_en1 = 1'b0; read_en2 = 1'b0;
    write_inst1 = '0; write_inst2 = '0; write_addr1 = '0; write_addr2 = '0;
  endtask

  task automatic push(input logic two, input logic [31:0] i1, input logic [31:0] a1,
                      input logic [31:0] i2, input logic [31:0] a2);
    write_en1 = 1'b1; write_en2 = two;
    write_inst1 = i1; write_addr1 = a1; write_inst2 = i2; write_addr2 = a2;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    tests++; if (fifo_almost_empty !== 1'b0) begin fails++; $display("FAIL reset_aempty got=%b exp=0", fifo_almost_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    tests++; if (read_inst1 !== 32'h0 || read_addr1 !== 32'h0) begin fails++; $display("FAIL reset_read1 got=%h/%h exp=0/0", read_inst1, read_addr1); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_push_pair();
    push(1'b1, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004);
    step();
    idle();
    tests++; if (read_inst1 !== 32'h24010001) begin fails++; $display("FAIL pair_inst1 got=%h exp=24010001", read_inst1); end
    tests++; if (read_inst2 !== 32'h24020002) begin fails++; $display("FAIL pair_inst2 got=%h exp=24020002", read_inst2); end
    tests++; if (read_addr1 !== 32'hBFC00000) begin fails++; $display("FAIL pair_addr1 got=%h exp=bfc00000", read_addr1); end
    tests++; if (read_addr2 !== 32'hBFC00004) begin fails++; $display("FAIL pair_addr2 got=%h exp=bfc00004", read_addr2); end
    tests++; if (fifo_empty !== 1'b0 || fifo_almost_empty !== 1'b0) begin fails++; $display("FAIL pair_flags got=%b%b exp=00", fifo_empty, fifo_almost_empty); end
  endtask

  task automatic test_pop_boundary();
    // count 2 -> single pop -> 1
    read_en1 = 1'b1;
    step();
    idle();
    tests++; if (fifo_almost_empty !== 1'b1) begin fails++; $display("FAIL pop1_aempty got=%b exp=1", fifo_almost_empty); end
    tests++; if (read_inst1 !== 32'h24020002 || read_inst2 !== 32'h0) begin fails++; $display("FAIL pop1_data got=%h/%h exp=24020002/0", read_inst1, read_inst2); end
    // count 1 with both read enables -> only one pop
    read_en1 = 1'b1; read_en2 = 1'b1;
    step();
    idle();
    tests++; if (fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b0) begin fails++; $display("FAIL pop_both_flags got=%b%b exp=10", fifo_empty, fifo_almost_empty); end
    tests++; if (read_inst1 !== 32'h0) begin fails++; $display("FAIL pop_both_inst1 got=%h exp=0", read_inst1); end
    // write_en2 alone is ignored
    write_en2 = 1'b1; write_inst2 = 32'hDEADBEEF; write_addr2 = 32'h1234;
    step();
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL wen2_alone got_empty=%b exp=1", fifo_empty); end
    // push and pop while empty -> pop not honoured, count 1
    push(1'b0, 32'hAAAA0001, 32'h00000040, 32'h0, 32'h0);
    read_en1 = 1'b1;
    step();
    idle();
    tests++; if (fifo_almost_empty !== 1'b1 || read_inst1 !== 32'hAAAA0001) begin fails++; $display("FAIL rw_empty got=%b/%h exp=1/aaaa0001", fifo_almost_empty, read_inst1); end
    // push and pop at count 1 -> count stays 1, new entry at head
    push(1'b0, 32'hAAAA0002, 32'h00000044, 32'h0, 32'h0);
    read_en1 = 1'b1;
    step();
    idle();
    tests++; if (fifo_almost_empty !== 1'b1 || read_addr1 !== 32'h00000044) begin fails++; $display("FAIL rw_one got=%b/%h exp=1/00000044", fifo_almost_empty, read_addr1); end
    flush = 1'b1;
    step();
    idle();
  endtask

  task automatic test_full();
    int exp_cnt;
    int e;
    for (int k = 0; k < 7; k++) begin
      push(1'b1, 32'h1000 + 32'(2*k), 32'h100 + 32'(8*k), 32'h1001 + 32'(2*k), 32'h104 + 32'(8*k));
      step();
    end
    idle();
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL full_at14 got=%b exp=0", fifo_full); end
    push(1'b0, 32'h100E, 32'h138, 32'h0, 32'h0);
    step();
    idle();
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL full_at15 got=%b exp=1", fifo_full); end
    push(1'b1, 32'hBAD00001, 32'hBAD0, 32'hBAD00002, 32'hBAD4);
    step();
    idle();
    tests++; if (fifo_full !== 1'b1 || read_inst1 !== 32'h1000 || read_inst2 !== 32'h1001) begin fails++; $display("FAIL full_drop got=%b/%h/%h exp=1/1000/1001", fifo_full, read_inst1, read_inst2); end
    exp_cnt = 15;
    e = 0;
    for (int it = 0; it < 20 && exp_cnt > 0; it++) begin
      tests++; if (read_addr1 !== 32'h100 + 32'(4*e)) begin fails++; $display("FAIL drain_addr1 idx=%0d got=%h exp=%h", e, read_addr1, 32'h100 + 32'(4*e)); end
      read_en1 = 1'b1;
      if (exp_cnt >= 2) begin
        tests++; if (read_addr2 !== 32'h104 + 32'(4*e)) begin fails++; $display("FAIL drain_addr2 idx=%0d got=%h exp=%h", e, read_addr2, 32'h104 + 32'(4*e)); end
        read_en2 = 1'b1;
        e += 2; exp_cnt -= 2;
      end else begin
        e += 1; exp_cnt -= 1;
      end
      step();
      idle();
    end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_back_to_back();
    int h;
    int w;
    push(1'b1, 32'd0, 32'h80000000, 32'd1, 32'h80000004);
    step();
    h = 0; w = 2;
    for (int c = 0; c < 40; c++) begin
      tests++; if (read_addr1 !== 32'h80000000 + 32'(4*h) || read_addr2 !== 32'h80000004 + 32'(4*h)) begin
        fails++; $display("FAIL wrap_order cyc=%0d got=%h/%h exp=%h/%h", c, read_addr1, read_addr2, 32'h80000000 + 32'(4*h), 32'h80000004 + 32'(4*h)); end
      tests++; if (fifo_empty !== 1'b0 || fifo_almost_empty !== 1'b0 || fifo_full !== 1'b0) begin
        fails++; $display("FAIL wrap_flags cyc=%0d got=%b%b%b exp=000", c, fifo_empty, fifo_almost_empty, fifo_full); end
      push(1'b1, 32'(w), 32'h80000000 + 32'(4*w), 32'(w+1), 32'h80000004 + 32'(4*w));
      read_en1 = 1'b1; read_en2 = 1'b1;
      step();
      h += 2; w += 2;
    end
    idle();
    tests++; if (read_inst1 !== 32'(h) || read_inst2 !== 32'(h+1)) begin fails++; $display("FAIL wrap_tail got=%h/%h exp=%h/%h", read_inst1, read_inst2, 32'(h), 32'(h+1)); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    idle();
    push(1'b1, 32'hC0, 32'h200, 32'hC1, 32'h204); step();
    push(1'b1, 32'hC2, 32'h208, 32'hC3, 32'h20C); step();
    push(1'b0, 32'hC4, 32'h210, 32'h0, 32'h0);    step();
    idle();
    tests++; if (read_inst1 !== 32'hC0 || fifo_empty !== 1'b0) begin fails++; $display("FAIL flush_pre got=%h/%b exp=c0/0", read_inst1, fifo_empty); end
    flush = 1'b1;
    push(1'b1, 32'hEE, 32'h300, 32'hEF, 32'h304);
    read_en1 = 1'b1; read_en2 = 1'b1;
    step();
    idle();
    tests++; if (fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b0 || fifo_full !== 1'b0) begin fails++; $display("FAIL flush_flags got=%b%b%b exp=100", fifo_empty, fifo_almost_empty, fifo_full); end
    tests++; if (read_inst1 !== 32'h0 || read_addr1 !== 32'h0 || read_inst2 !== 32'h0 || read_addr2 !== 32'h0) begin fails++; $display("FAIL flush_outputs got=%h/%h/%h/%h exp=0", read_inst1, read_addr1, read_inst2, read_addr2); end
    step();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL flush_discard got_empty=%b exp=1", fifo_empty); end
  endtask

`ifdef INST_FIFO_STARVE_CNT_EN
  task automatic test_starve();
    rst = 1'b1;
    #1;
    tests++; if (starve_cnt !== 32'd0) begin fails++; $display("FAIL starve_rst got=%0d exp=0", starve_cnt); end
    step();
    rst = 1'b0;
    push(1'b0, 32'h5, 32'h50, 32'h0, 32'h0);
    step();
    idle();
    for (int k = 0; k < 9; k++) step();
    tests++; if (starve_cnt !== 32'd10) begin fails++; $display("FAIL starve_10 got=%0d exp=10", starve_cnt); end
    flush = 1'b1;
    step();
    idle();
    tests++; if (starve_cnt !== 32'd10) begin fails++; $display("FAIL starve_flush got=%0d exp=10", starve_cnt); end
    step();
    #2;
    rst = 1'b1;
    #1;
    tests++; if (starve_cnt !== 32'd0) begin fails++; $display("FAIL starve_midrst got=%0d exp=0", starve_cnt); end
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_push_pair();
    test_pop_boundary();
    test_full();
    test_back_to_back();
    test_flush();
`ifdef INST_FIFO_STARVE_CNT_EN
    test_starve();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
